tt_mux_ctrl: RTL and testbench
==============================

Name: tt_mux_ctrl

Overview:
- Mux controller directly upstream of the per-project wrappers: owns the selected-project address, drives each wrapper's ena and the shared 18-bit iw bus, and returns the selected wrapper's 24-bit ow to the pads.
- The address is stepped by a pad-level increment/reset protocol.
- A guard FSM keeps every project disabled and held in reset while the selection changes.

Parameters:
- N_PROJ, 16, number of attached wrappers (1..2^ADDR_W).
- ADDR_W, 4, address counter width.
- GUARD, 4, cycles all projects stay disabled after any address change (1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sel_rst_n  in  1  async pad input, active-low; clears address.
- sel_inc  in  1  async pad input; rising edge increments address.
- ctrl_ena  in  1  async pad input; global enable.
- iw_pad  in  18  pad-side packed input {uio_in, ui_in, rst_n, clk}.
- ow_pad  out  24  pad-side packed output {uio_oe, uio_out, uo_out}.
- iw_bus  out  18  broadcast to all wrappers.
- ena_vec  out  N_PROJ  one-hot-or-zero wrapper enables.
- ow_bus  in  N_PROJ*24  concatenated wrapper outputs; project k at [24k+23:24k].
- cur_addr  out  ADDR_W  current address, for debug.
- active  out  1  high in ACTIVE state.

Behaviour:
- Sync: sel_rst_n, sel_inc and ctrl_ena each pass through a 2-FF synchronizer reset to inactive (sel_rst_n=1, sel_inc=0, ctrl_ena=0).
- sel_inc edge: a third flop provides the previous value. inc_pulse = s2 & ~s3, one cycle per rising edge. The address updates on the 3rd rising clk after sel_inc is first sampled high.
- Address: cur_addr resets to 0.
  - Synced sel_rst_n low holds cur_addr at 0 every cycle.
  - Otherwise inc_pulse adds 1 modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0).
  - sel_rst_n low has priority over a simultaneous inc_pulse.
- Address change event: any cycle where cur_addr is written with a different value, or a sel_rst_n low assertion (even if already 0).
- FSM states: IDLE, SWITCH, ACTIVE; reset state IDLE; 8-bit guard counter gcnt, reset 0.
  - IDLE: ena_vec=0, iw_bus=0. If synced ctrl_ena=1, go to SWITCH with gcnt=GUARD-1.
  - SWITCH: ena_vec=0, iw_bus=0.
    - ctrl_ena=0 -> IDLE.
    - Address change event -> reload gcnt=GUARD-1.
    - Else if gcnt==0 -> ACTIVE.
    - Else gcnt decrements.
  - ACTIVE:
    - ena_vec[cur_addr]=1 if cur_addr<N_PROJ, else ena_vec=0.
    - iw_bus=iw_pad.
    - ctrl_ena=0 -> IDLE.
    - Address change event -> SWITCH with gcnt=GUARD-1.
- Guard timing: with no further events, ACTIVE is entered exactly GUARD cycles after entering SWITCH.
- iw_bus=0 outside ACTIVE holds the wrapped project's clk low and its rst_n low.
- ow_pad:
  - ACTIVE and cur_addr<N_PROJ: ow_bus slice of cur_addr.
  - Otherwise: 24'h0.
  - Combinational from state and ow_bus in the base build.
- active = (state==ACTIVE).
- Reset values: ena_vec=0, iw_bus=0, ow_pad=0, cur_addr=0, active=0.
- Reset mid-operation: rst_n low asynchronously forces IDLE and all reset values, independent of clk.

Optional Feature:
- Macro: TT_MUX_OW_REG_EN.
- Defined: ow_pad is registered. It equals the above combinational value delayed 1 clk, reset value 0. The ACTIVE->SWITCH/IDLE transition zeroes the register on the same edge, so no stale project data reaches the pads after deselect.
- Undefined: ow_pad is combinational as specified, latency 0.

Test Plan:
- Reset, ctrl_ena=1, no sel activity -> after sync (2 clk) plus GUARD=4 cycles in SWITCH: active=1, ena_vec=16'h0001, iw_bus follows iw_pad, ow_pad=ow_bus[23:0].
- In ACTIVE at addr 0, pulse sel_inc 3 times (each pulse 4 clk high, 4 low):
  - each edge drops ena_vec to 0 and iw_bus to 0 for 4 cycles;
  - final cur_addr=3, ena_vec=16'h0008, ow_pad=ow_bus[95:72].
- Step cur_addr to 15, then one more sel_inc -> cur_addr wraps to 0, re-enters ACTIVE with ena_vec=16'h0001.
- N_PROJ=10, step to cur_addr=12 -> ACTIVE reached, ena_vec=0, ow_pad=24'h0, iw_bus=iw_pad.
- sel_rst_n low and a sel_inc rising edge landing on the same synced cycle at addr 5 -> cur_addr=0, FSM in SWITCH; ACTIVE with ena_vec bit0 only after sel_rst_n returns high plus GUARD cycles.
- Deassert rst_n asynchronously mid-SWITCH, and separately drop ctrl_ena in ACTIVE -> immediate all-zero outputs and IDLE. With TT_MUX_OW_REG_EN: ow_pad lags ow_bus by exactly 1 clk in ACTIVE and reads 0 on the cycle after leaving ACTIVE.

Source files
------------

// File: rtl/tt_mux_ctrl.sv
// tt_mux_ctrl: project mux controller sitting in front of the per-project wrappers.
// Holds the selected-project address, which is stepped from the pads by sel_inc
// (a rising edge increments) and cleared by sel_rst_n. Drives the one-hot wrapper
// enables and the shared iw bus, and returns the selected wrapper's ow to the pads.
// A guard FSM keeps every project disabled (iw bus zero, so the wrapped clk and
// rst_n are low) for GUARD cycles after any address change.
//
// Optional build macro TT_MUX_OW_REG_EN: registers ow_pad, adding one clk of
// latency. The register is zeroed on the same edge that leaves ACTIVE, so no
// stale project data reaches the pads after a deselect.

// Per-project lane: enable decode and masked output slice for one wrapper.
module tt_mux_lane #(
  parameter int ADDR_W  = 4,
  parameter int LANE_ID = 0
) (
  input  logic              act,
  input  logic [ADDR_W-1:0] addr,
  input  logic [23:0]       ow_in,
  output logic              ena,
  output logic [23:0]       ow_out
);

  localparam logic [ADDR_W-1:0] ID = ADDR_W'(LANE_ID);

  assign ena    = act && (addr == ID);
  assign ow_out = ena ? ow_in : 24'h0;

endmodule

module tt_mux_ctrl #(
  parameter int N_PROJ = 16,
  parameter int ADDR_W = 4,
  parameter int GUARD  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sel_rst_n,
  input  logic                 sel_inc,
  input  logic                 ctrl_ena,
  input  logic [17:0]          iw_pad,
  output logic [23:0]          ow_pad,
  output logic [17:0]          iw_bus,
  output logic [N_PROJ-1:0]    ena_vec,
  input  logic [N_PROJ*24-1:0] ow_bus,
  output logic [ADDR_W-1:0]    cur_addr,
  output logic                 active
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [7:0] GLOAD = 8'(GUARD - 1);

  // Pad synchronizers. Each resets to its inactive level so a reset never
  // looks like a pad event.
  logic srst_s1, srst_s2;
  logic inc_s1, inc_s2, inc_s3;
  logic ena_s1, ena_s2;

  logic inc_pulse;
  logic addr_evt;

  state_t     state, nstate;
  logic [7:0] gcnt, gcnt_n;

  logic [ADDR_W-1:0]         addr_q;
  logic                      act;
  logic [N_PROJ-1:0][23:0]   ow_lane;
  logic [23:0]               ow_sel;

  // Two-flop synchronizers for the pad controls, plus a third flop on sel_inc
  // to hold the previous synced value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srst_s1 <= 1'b1;
      srst_s2 <= 1'b1;
      inc_s1  <= 1'b0;
      inc_s2  <= 1'b0;
      inc_s3  <= 1'b0;
      ena_s1  <= 1'b0;
      ena_s2  <= 1'b0;
    end else begin
      srst_s1 <= sel_rst_n;
      srst_s2 <= srst_s1;
      inc_s1  <= sel_inc;
      inc_s2  <= inc_s1;
      inc_s3  <= inc_s2;
      ena_s1  <= ctrl_ena;
      ena_s2  <= ena_s1;
    end
  end

  // One cycle per synced rising edge of sel_inc.
  assign inc_pulse = inc_s2 & ~inc_s3;

  // An increment always changes the address (modulo wrap still differs), and
  // a held clear counts as a change every cycle, even when already at zero.
  assign addr_evt = ~srst_s2 | inc_pulse;

  // Address counter: clear wins over a coincident increment; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (!srst_s2) begin
      addr_q <= '0;
    end else if (inc_pulse) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  // Guard FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gcnt  <= 8'd0;
    end else begin
      state <= nstate;
      gcnt  <= gcnt_n;
    end
  end

  // Guard FSM next state: any address change (re)starts the guard window, and
  // ACTIVE is only reached once the window expires with ctrl_ena still high.
  always_comb begin
    nstate = state;
    gcnt_n = gcnt;
    case (state)
      IDLE: begin
        if (ena_s2) begin
          nstate = SWITCH;
          gcnt_n = GLOAD;
        end
      end
      SWITCH: begin
        if (!ena_s2) begin
          nstate = IDLE;
        end else if (addr_evt) begin
          gcnt_n = GLOAD;
        end else if (gcnt == 8'd0) begin
          nstate = ACTIVE;
        end else begin
          gcnt_n = gcnt - 8'd1;
        end
      end
      ACTIVE: begin
        if (!ena_s2) begin
          nstate = IDLE;
        end else if (addr_evt) begin
          nstate = SWITCH;
          gcnt_n = GLOAD;
        end
      end
      default: begin
        nstate = IDLE;
      end
    endcase
  end

  assign act      = (state == ACTIVE);
  assign active   = act;
  assign cur_addr = addr_q;

  // Zero outside ACTIVE keeps the wrapped project's clk and rst_n low.
  assign iw_bus = act ? iw_pad : 18'h0;

  // One lane per wrapper; an address past N_PROJ-1 matches no lane, so the
  // enables and the returned output both go to zero.
  genvar k;
  generate
    for (k = 0; k < N_PROJ; k++) begin : g_lane
      tt_mux_lane #(
        .ADDR_W  (ADDR_W),
        .LANE_ID (k)
      ) u_lane (
        .act    (act),
        .addr   (addr_q),
        .ow_in  (ow_bus[k*24 +: 24]),
        .ena    (ena_vec[k]),
        .ow_out (ow_lane[k])
      );
    end
  endgenerate

  // Enables are one-hot-or-zero, so an OR of the masked slices is the mux.
  always_comb begin
    ow_sel = 24'h0;
    for (int i = 0; i < N_PROJ; i++) begin
      ow_sel = ow_sel | ow_lane[i];
    end
  end

`ifdef TT_MUX_OW_REG_EN
  logic [23:0] ow_q;

  // Registered pad output, cleared on the edge that leaves ACTIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ow_q <= 24'h0;
    end else if (nstate == ACTIVE) begin
      ow_q <= ow_sel;
    end else begin
      ow_q <= 24'h0;
    end
  end

  assign ow_pad = ow_q;
`else
  assign ow_pad = ow_sel;
`endif

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Bench for tt_mux_ctrl: two instances share all stimulus, one with 16 projects
// and one with 10 so that addresses 10..15 exercise the out-of-range case.
module tb_tt_mux_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel_rst_n = 1'b1;
  logic        sel_inc = 1'b0;
  logic        ctrl_ena = 1'b0;
  logic [17:0] iw_pad;
  logic [383:0] ow_bus;

  logic [23:0] ow16, ow10;
  logic [17:0] iw16, iw10;
  logic [15:0] ena16;
  logic [9:0]  ena10;
  logic [3:0]  addr16, addr10;
  logic        act16, act10;

  always #5 clk = ~clk;

  tt_mux_ctrl #(.N_PROJ(16), .ADDR_W(4), .GUARD(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .sel_rst_n(sel_rst_n), .sel_inc(sel_inc),
    .ctrl_ena(ctrl_ena), .iw_pad(iw_pad), .ow_pad(ow16), .iw_bus(iw16),
    .ena_vec(ena16), .ow_bus(ow_bus), .cur_addr(addr16), .active(act16)
  );

  tt_mux_ctrl #(.N_PROJ(10), .ADDR_W(4), .GUARD(4)) dut10 (
    .clk(clk), .rst_n(rst_n), .sel_rst_n(sel_rst_n), .sel_inc(sel_inc),
    .ctrl_ena(ctrl_ena), .iw_pad(iw_pad), .ow_pad(ow10), .iw_bus(iw10),
    .ena_vec(ena10), .ow_bus(ow_bus[239:0]), .cur_addr(addr10), .active(act10)
  );

  typedef struct packed {
    logic        act;
    logic [3:0]  addr;
    logic [15:0] ena16;
    logic [9:0]  ena10;
    logic [17:0] iw;
    logic [23:0] ow16;
    logic [23:0] ow10;
  } exp_t;

  exp_t  sbq[$];
  string tagq[$];
  int    n_chk = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected pad/bus view for a given FSM activity and address.
  function automatic exp_t mk(input logic act, input logic [3:0] addr);
    exp_t e;
    e.act   = act;
    e.addr  = addr;
    e.ena16 = act ? (16'h1 << addr) : 16'h0;
    e.ena10 = (act && addr < 4'd10) ? (10'h1 << addr) : 10'h0;
    e.iw    = act ? iw_pad : 18'h0;
    e.ow16  = act ? ow_bus[addr*24 +: 24] : 24'h0;
    e.ow10  = (act && addr < 4'd10) ? ow_bus[addr*24 +: 24] : 24'h0;
    return e;
  endfunction

  task automatic push(input string tag, input logic act, input logic [3:0] addr);
    sbq.push_back(mk(act, addr));
    tagq.push_back(tag);
  endtask

  task automatic pop_chk;
    exp_t  e;
    string t;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sbq.pop_front();
    t = tagq.pop_front();
    chk({t, ".active"},  32'(act16),  32'(e.act));
    chk({t, ".active10"}, 32'(act10), 32'(e.act));
    chk({t, ".addr"},    32'(addr16), 32'(e.addr));
    chk({t, ".addr10"},  32'(addr10), 32'(e.addr));
    chk({t, ".ena16"},   32'(ena16),  32'(e.ena16));
    chk({t, ".ena10"},   32'(ena10),  32'(e.ena10));
    chk({t, ".iw16"},    32'(iw16),   32'(e.iw));
    chk({t, ".iw10"},    32'(iw10),   32'(e.iw));
    chk({t, ".ow16"},    32'(ow16),   32'(e.ow16));
    chk({t, ".ow10"},    32'(ow10),   32'(e.ow10));
  endtask

  task automatic wait_act(output int n);
    n = 0;
    while (!act16 && n < 50) begin
      tick(1);
      n++;
    end
  endtask

  // One sel_inc pulse (4 clk high, 4 low) from a steady ACTIVE state: still
  // active 2 edges in, guarded from edge 3 to edge 7, steady again at edge 8.
  task automatic inc_step(input logic [3:0] from);
    logic [3:0] to;
    to = from + 4'd1;
    iw_pad = 18'($urandom);
    push($sformatf("pre%0d", from), 1'b1, from);
    push($sformatf("sw%0d", to), 1'b0, to);
    push($sformatf("post%0d", to), 1'b1, to);
    sel_inc = 1'b1;
    tick(2);
    pop_chk();
    tick(1);
    pop_chk();
    tick(1);
    sel_inc = 1'b0;
    tick(4);
    pop_chk();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [23:0] old_ow;

    iw_pad = 18'h2A5C3;
    for (int k = 0; k < 16; k++)
      ow_bus[k*24 +: 24] = {8'(8'hA0 + k), 8'h5A, 8'(k * 7 + 3)};

    // Reset state
    tick(2);
    push("rst", 1'b0, 4'd0);
    pop_chk();

    // Enable: 2 sync edges, 1 into SWITCH, GUARD in SWITCH
    rst_n = 1'b1;
    ctrl_ena = 1'b1;
    wait_act(n);
    chk("t_first_active", 32'(n), 32'd7);
    tick(1);
    push("act0", 1'b1, 4'd0);
    pop_chk();

    iw_pad = 18'h3FFFF;
    push("iw_follow", 1'b1, 4'd0);
    #1;
    pop_chk();

    // Step through every address and wrap back to 0
    for (int a = 0; a < 16; a++) inc_step(4'(a));
    for (int a = 0; a < 5; a++) inc_step(4'(a));

    // Clear and increment landing on the same synced cycle at address 5
    push("coll", 1'b0, 4'd0);
    push("coll_hold", 1'b0, 4'd0);
    sel_rst_n = 1'b0;
    sel_inc = 1'b1;
    tick(3);
    pop_chk();
    tick(1);
    sel_inc = 1'b0;
    tick(4);
    pop_chk();
    sel_rst_n = 1'b1;
    wait_act(n);
    chk("t_clear_release", 32'(n), 32'd6);
    tick(1);
    push("after_coll", 1'b1, 4'd0);
    pop_chk();

    inc_step(4'd0);

    // Output path latency
    old_ow = ow_bus[24 +: 24];
    ow_bus[24 +: 24] = 24'hC0FFEE;
    #1;
`ifdef TT_MUX_OW_REG_EN
    chk("ow_lag_pre", 32'(ow16), 32'(old_ow));
    tick(1);
    chk("ow_lag_post", 32'(ow16), 32'h00C0FFEE);
`else
    chk("ow_comb_old", 32'(old_ow), 32'(old_ow ^ 24'h0));
    chk("ow_comb", 32'(ow16), 32'h00C0FFEE);
`endif

    // Drop ctrl_ena in ACTIVE
    push("drop_pre", 1'b1, 4'd1);
    push("drop", 1'b0, 4'd1);
    ctrl_ena = 1'b0;
    tick(2);
    pop_chk();
    tick(1);
    pop_chk();

    // Async reset mid-SWITCH
    ctrl_ena = 1'b1;
    tick(4);
    push("sw_pre", 1'b0, 4'd1);
    pop_chk();
    #2;
    rst_n = 1'b0;
    #1;
    push("async_rst", 1'b0, 4'd0);
    pop_chk();
    #1;
    rst_n = 1'b1;
    wait_act(n);
    chk("t_rearm_active", 32'(n), 32'd7);
    tick(1);
    push("rearm", 1'b1, 4'd0);
    pop_chk();

    chk("sb_drain", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
